// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM encoding, CSR
// addresses, mcause values and mstatus field positions.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;
   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_L_FAULT = 32'd5;
   localparam logic [31:0] CAUSE_S_FAULT = 32'd7;
   localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MPP_HI   = 12;
   localparam int MPP_LO   = 11;

   localparam logic [1:0] WSC_WRITE = 2'b01;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      T_STATUS = 3'd1,
      T_EPC    = 3'd2,
      T_CAUSE  = 3'd3,
      RET      = 3'd4,
`ifdef TRAP_MTVAL_EN
      T_TVAL   = 3'd6,
`endif
      REDIRECT = 3'd5
   } trap_state_e;

   // mstatus image on trap entry: stash MIE in MPIE, mask interrupts, MPP = M.
   function automatic logic [31:0] trap_entry_mstatus(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      r[MPIE_BIT]      = s[MIE_BIT];
      r[MIE_BIT]       = 1'b0;
      r[MPP_HI:MPP_LO] = 2'b11;
      return r;
   endfunction

   // mstatus image on mret: restore MIE from MPIE and set MPIE.
   function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
      logic [31:0] r;
      r = s;
      r[MIE_BIT]  = s[MPIE_BIT];
      r[MPIE_BIT] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/trap_cause_enc.sv
// Priority encoder for pending trap causes; interrupts only count when MIE is set.
module trap_cause_enc
   import trap_pkg::*;
(
   input  logic        interrupt,
   input  logic        illegal_inst,
   input  logic        ecall_m,
   input  logic        s_access_fault,
   input  logic        l_access_fault,
   input  logic        mie,
   output logic        take,
   output logic [31:0] cause,
   output logic        is_irq
);

   always_comb begin
      take   = 1'b1;
      is_irq = 1'b0;
      cause  = '0;
      if (interrupt && mie) begin
         is_irq = 1'b1;
         cause  = CAUSE_IRQ;
      end else if (illegal_inst) begin
         cause = CAUSE_ILLEGAL;
      end else if (ecall_m) begin
         cause = CAUSE_ECALL_M;
      end else if (s_access_fault) begin
         cause = CAUSE_S_FAULT;
      end else if (l_access_fault) begin
         cause = CAUSE_L_FAULT;
      end else begin
         take = 1'b0;
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Owns the CSR port: passes MEM-stage CSR ops through in IDLE and sequences
// trap entry / mret writes. Define TRAP_MTVAL_EN to add the mtval write.
module trap_sequencer
   import trap_pkg::*;
#(
   parameter logic [11:0] MTVEC_ADDR   = CSR_MTVEC,
   parameter logic [11:0] MEPC_ADDR    = CSR_MEPC,
   parameter logic [11:0] MCAUSE_ADDR  = CSR_MCAUSE,
   parameter logic [11:0] MSTATUS_ADDR = CSR_MSTATUS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_rw_in,
   input  logic [1:0]  csr_wsc_mode_in,
   input  logic        csr_w_imm_mux,
   input  logic [11:0] csr_rw_addr_in,
   input  logic [31:0] csr_w_data_reg,
   input  logic [4:0]  csr_w_data_imm,
   input  logic        interrupt,
   input  logic        illegal_inst,
   input  logic        l_access_fault,
   input  logic        s_access_fault,
   input  logic        ecall_m,
   input  logic        mret,
   input  logic [31:0] epc_cur,
   input  logic [31:0] epc_next,
   input  logic [31:0] mstatus_in,
   input  logic [31:0] csr_rdata_in,
`ifdef TRAP_MTVAL_EN
   input  logic [31:0] fault_addr,
`endif
   output logic        csr_w,
   output logic [1:0]  csr_wsc,
   output logic [11:0] csr_waddr,
   output logic [11:0] csr_raddr,
   output logic [31:0] csr_wdata,
   output logic [31:0] pc_redirect,
   output logic        redirect_valid,
   output logic        flush_all,
   output logic        regwrite_cancel,
   output logic        stall_pipe,
   output logic        busy,
   output trap_state_e state_dbg
);

   trap_state_e state_q, state_d;
   logic [31:0] cause_q, epc_q, tvec_q;
   logic        take, is_irq;
   logic [31:0] enc_cause;
`ifdef TRAP_MTVAL_EN
   logic [31:0] mtval_q;
`endif

   trap_cause_enc u_cause_enc (
      .interrupt      (interrupt),
      .illegal_inst   (illegal_inst),
      .ecall_m        (ecall_m),
      .s_access_fault (s_access_fault),
      .l_access_fault (l_access_fault),
      .mie            (mstatus_in[MIE_BIT]),
      .take           (take),
      .cause          (enc_cause),
      .is_irq         (is_irq)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cause_q <= '0;
         epc_q   <= '0;
         tvec_q  <= '0;
`ifdef TRAP_MTVAL_EN
         mtval_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && take) begin
            cause_q <= enc_cause;
            epc_q   <= is_irq ? {epc_next[31:2], 2'b00} : {epc_cur[31:2], 2'b00};
`ifdef TRAP_MTVAL_EN
            mtval_q <= fault_addr;
`endif
         end
         if (state_q == T_CAUSE) tvec_q <= {csr_rdata_in[31:2], 2'b00};
         if (state_q == RET)     tvec_q <= csr_rdata_in;
      end
   end

   always_comb begin
      state_d         = state_q;
      csr_w           = 1'b0;
      csr_wsc         = 2'b00;
      csr_waddr       = '0;
      csr_raddr       = '0;
      csr_wdata       = '0;
      pc_redirect     = '0;
      redirect_valid  = 1'b0;
      flush_all       = 1'b0;
      regwrite_cancel = 1'b0;
      stall_pipe      = 1'b0;
      busy            = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (take) begin
               regwrite_cancel = 1'b1;
               flush_all       = 1'b1;
               stall_pipe      = 1'b1;
               state_d         = T_STATUS;
            end else if (mret) begin
               state_d = RET;
            end else if (csr_rw_in) begin
               csr_w     = 1'b1;
               csr_wsc   = csr_wsc_mode_in;
               csr_waddr = csr_rw_addr_in;
               csr_raddr = csr_rw_addr_in;
               csr_wdata = csr_w_imm_mux ? {27'b0, csr_w_data_imm} : csr_w_data_reg;
            end
         end
         T_STATUS: begin
            {csr_w, csr_wsc, csr_waddr} = {1'b1, WSC_WRITE, MSTATUS_ADDR};
            csr_wdata  = trap_entry_mstatus(mstatus_in);
            flush_all  = 1'b1;
            stall_pipe = 1'b1;
            state_d    = T_EPC;
         end
         T_EPC: begin
            {csr_w, csr_wsc, csr_waddr} = {1'b1, WSC_WRITE, MEPC_ADDR};
            csr_wdata  = epc_q;
            flush_all  = 1'b1;
            stall_pipe = 1'b1;
            state_d    = T_CAUSE;
         end
         T_CAUSE: begin
            {csr_w, csr_wsc, csr_waddr} = {1'b1, WSC_WRITE, MCAUSE_ADDR};
            csr_wdata  = cause_q;
            csr_raddr  = MTVEC_ADDR;
            flush_all  = 1'b1;
            stall_pipe = 1'b1;
`ifdef TRAP_MTVAL_EN
            state_d    = T_TVAL;
`else
            state_d    = REDIRECT;
`endif
         end
`ifdef TRAP_MTVAL_EN
         T_TVAL: begin
            {csr_w, csr_wsc, csr_waddr} = {1'b1, WSC_WRITE, CSR_MTVAL};
            // Only memory faults carry a meaningful address.
            csr_wdata  = (cause_q == CAUSE_L_FAULT || cause_q == CAUSE_S_FAULT) ? mtval_q : '0;
            flush_all  = 1'b1;
            stall_pipe = 1'b1;
            state_d    = REDIRECT;
         end
`endif
         RET: begin
            {csr_w, csr_wsc, csr_waddr} = {1'b1, WSC_WRITE, MSTATUS_ADDR};
            csr_wdata  = mret_mstatus(mstatus_in);
            csr_raddr  = MEPC_ADDR;
            flush_all  = 1'b1;
            stall_pipe = 1'b1;
            state_d    = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            pc_redirect    = tvec_q;
            flush_all      = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign state_dbg = state_q;

endmodule
